time_set_ctrl: RTL and testbench

User time-entry controller sitting directly upstream of the decimal clockwork. Takes debounced single-cycle button pulses, snapshots the running BCD time, and lets the user edit hours, minutes and seconds in turn. On commit it drives the 20-bit `time_in` bus and holds `time_ow` long enough for the slow 1 Hz clockwork domain to sample the overwrite.

---
 rtl/time_pkg.sv | 37 +++
 rtl/bcd_field_step.sv | 38 +++
 rtl/time_set_ctrl.sv | 140 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared definitions for the time-entry controller: BCD field layout, limits,
// field-select encodings and the controller state enum.
package time_pkg;

  localparam int HOUR_W = 6;
  localparam int MIN_W  = 7;
  localparam int SEC_W  = 7;
  localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

  // Bus packing: {hour, min, sec}, seconds in the low bits.
  localparam int SEC_LSB  = 0;
  localparam int MIN_LSB  = SEC_LSB + SEC_W;
  localparam int HOUR_LSB = MIN_LSB + MIN_W;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HOUR = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_H = 3'd1,
    ST_EDIT_M = 3'd2,
    ST_EDIT_S = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  function automatic logic [TIME_W-1:0] pack_time(input logic [HOUR_W-1:0] h,
                                                  input logic [MIN_W-1:0]  m,
                                                  input logic [SEC_W-1:0]  s);
    return {h, m, s};
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational single-step increment/decrement of one packed BCD field with
// wrap at MAX; illegal inputs step to 00, no step (or both) passes through.
module bcd_field_step #(
  parameter int         W   = 7,
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [W-1:0] val_i,
  input  logic         up_i,
  input  logic         dn_i,
  output logic [W-1:0] val_o
);

  logic [7:0] v;
  logic [7:0] r;
  logic [3:0] units;
  logic [3:0] tens;
  logic       legal;

  always_comb begin
    v     = 8'(val_i);
    units = v[3:0];
    tens  = v[7:4];
    legal = (units <= 4'd9) && (v <= MAX);
    r     = v;
    if (up_i && !dn_i) begin
      if (!legal || v == MAX)  r = 8'h00;
      else if (units == 4'd9)  r = {tens + 4'd1, 4'd0};
      else                     r = {tens, units + 4'd1};
    end else if (dn_i && !up_i) begin
      if (!legal)              r = 8'h00;
      else if (v == 8'h00)     r = MAX;
      else if (units == 4'd0)  r = {tens - 4'd1, 4'd9};
      else                     r = {tens, units - 4'd1};
    end
    val_o = W'(r);
  end

endmodule

// File: rtl/time_set_ctrl.sv
// User time-entry controller: snapshot, edit h/m/s, then hold time_ow for OW_HOLD.
// Optional inactivity abort of editing is enabled by defining TIME_SET_TIMEOUT_EN.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int OW_HOLD        = 100_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic [TIME_W-1:0] time_cur,
  output logic [TIME_W-1:0] time_in,
  output logic              time_ow,
  output logic              editing,
  output logic [1:0]        field_sel,
  output logic [2:0]        dbg_state_o
);

  localparam int HW = $clog2(OW_HOLD + 1);

  state_t             state_q, state_d;
  logic [TIME_W-1:0]  edit_q, edit_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               ow_q, ow_d;
  logic               editing_q, editing_d;
  logic [1:0]         fsel_q, fsel_d;
  logic               in_edit, step_ok, any_btn, quiet_expired;
  logic [HOUR_W-1:0]  hour_nx;
  logic [MIN_W-1:0]   min_nx;
  logic [SEC_W-1:0]   sec_nx;

  assign in_edit = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) || (state_q == ST_EDIT_S);
  assign step_ok = in_edit && !btn_mode;
  assign any_btn = btn_mode || btn_up || btn_down;

  bcd_field_step #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .val_i (edit_q[HOUR_LSB +: HOUR_W]),
    .up_i  (step_ok && (state_q == ST_EDIT_H) && btn_up),
    .dn_i  (step_ok && (state_q == ST_EDIT_H) && btn_down),
    .val_o (hour_nx)
  );

  bcd_field_step #(.W(MIN_W), .MAX(MINSEC_MAX)) u_min (
    .val_i (edit_q[MIN_LSB +: MIN_W]),
    .up_i  (step_ok && (state_q == ST_EDIT_M) && btn_up),
    .dn_i  (step_ok && (state_q == ST_EDIT_M) && btn_down),
    .val_o (min_nx)
  );

  bcd_field_step #(.W(SEC_W), .MAX(MINSEC_MAX)) u_sec (
    .val_i (edit_q[SEC_LSB +: SEC_W]),
    .up_i  (step_ok && (state_q == ST_EDIT_S) && btn_up),
    .dn_i  (step_ok && (state_q == ST_EDIT_S) && btn_down),
    .val_o (sec_nx)
  );

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] quiet_q, quiet_d;

  always_comb begin
    quiet_d = '0;
    if (in_edit && !any_btn) quiet_d = quiet_q + TW'(1);
  end

  assign quiet_expired = in_edit && !any_btn && (quiet_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) quiet_q <= '0;
    else     quiet_q <= quiet_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0) || any_btn;
  assign quiet_expired  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: if (btn_mode) begin
        state_d = ST_EDIT_H;
        edit_d  = time_cur;
      end
      ST_EDIT_H: if (btn_mode) state_d = ST_EDIT_M;
      ST_EDIT_M: if (btn_mode) state_d = ST_EDIT_S;
      ST_EDIT_S: if (btn_mode) begin
        state_d = ST_COMMIT;
        hold_d  = '0;
      end
      ST_COMMIT: begin
        if (hold_q == HW'(OW_HOLD - 1)) state_d = ST_IDLE;
        else                            hold_d  = hold_q + HW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (step_ok) edit_d = pack_time(hour_nx, min_nx, sec_nx);
    if (quiet_expired) state_d = ST_IDLE;

    // Outputs are registered from the next state so they move with it.
    ow_d      = (state_d == ST_COMMIT);
    editing_d = (state_d != ST_IDLE);
    case (state_d)
      ST_EDIT_H: fsel_d = FSEL_HOUR;
      ST_EDIT_M: fsel_d = FSEL_MIN;
      ST_EDIT_S: fsel_d = FSEL_SEC;
      default:   fsel_d = FSEL_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      edit_q    <= '0;
      hold_q    <= '0;
      ow_q      <= 1'b0;
      editing_q <= 1'b0;
      fsel_q    <= FSEL_NONE;
    end else begin
      state_q   <= state_d;
      edit_q    <= edit_d;
      hold_q    <= hold_d;
      ow_q      <= ow_d;
      editing_q <= editing_d;
      fsel_q    <= fsel_d;
    end
  end

  assign time_in     = edit_q;
  assign time_ow     = ow_q;
  assign editing     = editing_q;
  assign field_sel   = fsel_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized
// traffic against a decimal-arithmetic reference model.
module tb_time_set_ctrl;

  localparam int OW_HOLD        = 5;
  localparam int TIMEOUT_CYCLES = 20;

  logic        clk;
  logic        rst, btn_mode, btn_up, btn_down;
  logic [19:0] time_cur, time_in;
  logic        time_ow, editing;
  logic [1:0]  field_sel;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 idle, 1..3 editing hour/min/sec, 4 commit
  int          m_mode;
  int          m_left;
  int          m_quiet;
  logic [19:0] m_edit;

  time_set_ctrl #(.OW_HOLD(OW_HOLD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .time_cur    (time_cur),
    .time_in     (time_in),
    .time_ow     (time_ow),
    .editing     (editing),
    .field_sel   (field_sel),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_step(input int v, input int max_dec, input int dir);
    int tens, units, d;
    tens  = v / 16;
    units = v % 16;
    if (units > 9 || tens * 10 + units > max_dec) return 0;
    d = (tens * 10 + units + dir + max_dec + 1) % (max_dec + 1);
    return (d / 10) * 16 + d % 10;
  endfunction

  function automatic logic [19:0] rand_legal();
    int h, m, s;
    h = $urandom_range(0, 23);
    m = $urandom_range(0, 59);
    s = $urandom_range(0, 59);
    return {6'((h / 10) * 16 + h % 10), 7'((m / 10) * 16 + m % 10), 7'((s / 10) * 16 + s % 10)};
  endfunction

  function automatic logic [23:0] model_outs();
    logic [1:0] fs;
    fs = (m_mode >= 1 && m_mode <= 3) ? 2'(m_mode) : 2'd0;
    return {m_edit, (m_mode == 4), (m_mode != 0), fs};
  endfunction

  task automatic model_update(input logic r, input logic m, input logic u, input logic d);
    int dir;
    if (r) begin
      m_mode = 0; m_edit = '0; m_left = 0; m_quiet = 0;
      return;
    end
    dir = (u && !d) ? 1 : ((d && !u) ? -1 : 0);
    case (m_mode)
      0: if (m) begin m_mode = 1; m_edit = time_cur; m_quiet = 0; end
      1, 2, 3: begin
        if (m) begin
          m_quiet = 0;
          if (m_mode == 3) begin m_mode = 4; m_left = OW_HOLD; end
          else m_mode = m_mode + 1;
        end else begin
          if (dir != 0) begin
            if (m_mode == 1) m_edit[19:14] = 6'(bcd_step(int'(m_edit[19:14]), 23, dir));
            if (m_mode == 2) m_edit[13:7]  = 7'(bcd_step(int'(m_edit[13:7]), 59, dir));
            if (m_mode == 3) m_edit[6:0]   = 7'(bcd_step(int'(m_edit[6:0]), 59, dir));
          end
`ifdef TIME_SET_TIMEOUT_EN
          if (u || d) m_quiet = 0;
          else begin
            m_quiet = m_quiet + 1;
            if (m_quiet >= TIMEOUT_CYCLES) begin m_mode = 0; m_quiet = 0; end
          end
`endif
        end
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic drive(input logic r, input logic m, input logic u, input logic d);
    rst = r; btn_mode = m; btn_up = u; btn_down = d;
    @(posedge clk);
    model_update(r, m, u, d);
    #1;
    rst = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
  endtask

  task automatic test_reset();
    time_cur = rand_legal();
    drive(1, 0, 0, 0);
    drive(1, 1, 1, 0);
    n_checks++;
    if ({time_in, time_ow, editing, field_sel} !== 24'h0)
      $display("FAIL reset_outputs got=%h exp=%h", {time_in, time_ow, editing, field_sel}, 24'h0);
    else n_pass++;
  endtask

  task automatic test_enter_edit();
    logic [19:0] t;
    t = {6'h23, 7'h48, 7'h00};
    time_cur = t;
    drive(0, 1, 0, 0);
    n_checks++;
    if (field_sel !== 2'd1) $display("FAIL enter_fsel got=%0d exp=1", field_sel); else n_pass++;
    n_checks++;
    if (time_in !== t) $display("FAIL enter_time_in got=%h exp=%h", time_in, t); else n_pass++;
    n_checks++;
    if (editing !== 1'b1 || time_ow !== 1'b0) $display("FAIL enter_editing got=%b%b exp=10", editing, time_ow); else n_pass++;
    time_cur = rand_legal();
  endtask

  task automatic test_hour_steps();
    drive(0, 0, 1, 0);
    n_checks++;
    if (time_in !== {6'h00, 7'h48, 7'h00}) $display("FAIL hour_up_wrap got=%h exp=%h", time_in, {6'h00, 7'h48, 7'h00}); else n_pass++;
    drive(0, 0, 0, 1);
    n_checks++;
    if (time_in[19:14] !== 6'h23) $display("FAIL hour_down_wrap got=%h exp=23", time_in[19:14]); else n_pass++;
    repeat (4) drive(0, 0, 0, 1);
    n_checks++;
    if (time_in !== {6'h19, 7'h48, 7'h00}) $display("FAIL hour_down_20_19 got=%h exp=%h", time_in, {6'h19, 7'h48, 7'h00}); else n_pass++;
  endtask

  task automatic test_mode_priority();
    drive(0, 1, 1, 0);
    n_checks++;
    if (field_sel !== 2'd2 || time_in !== {6'h19, 7'h48, 7'h00})
      $display("FAIL mode_wins got=%0d/%h exp=2/%h", field_sel, time_in, {6'h19, 7'h48, 7'h00});
    else n_pass++;
  endtask

  task automatic test_minsec();
    repeat (11) drive(0, 0, 1, 0);
    n_checks++;
    if (time_in[13:7] !== 7'h59) $display("FAIL min_to_59 got=%h exp=59", time_in[13:7]); else n_pass++;
    drive(0, 0, 1, 0);
    n_checks++;
    if (time_in !== {6'h19, 7'h00, 7'h00}) $display("FAIL min_wrap got=%h exp=%h", time_in, {6'h19, 7'h00, 7'h00}); else n_pass++;
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    n_checks++;
    if (field_sel !== 2'd3 || time_in !== {6'h19, 7'h00, 7'h59})
      $display("FAIL sec_down_wrap got=%0d/%h exp=3/%h", field_sel, time_in, {6'h19, 7'h00, 7'h59});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 1, 1);
    n_checks++;
    if (time_in !== {6'h19, 7'h00, 7'h59} || field_sel !== 2'd3)
      $display("FAIL up_down_together got=%0d/%h exp=3/%h", field_sel, time_in, {6'h19, 7'h00, 7'h59});
    else n_pass++;
  endtask

  task automatic test_commit();
    logic [19:0] frozen;
    int hi, guard;
    frozen = {6'h19, 7'h00, 7'h59};
    drive(0, 1, 0, 0);
    hi = (time_ow === 1'b1) ? 1 : 0;
    guard = 0;
    while (time_ow === 1'b1 && guard < 20) begin
      time_cur = rand_legal();
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_checks++;
      if (time_in !== frozen) $display("FAIL commit_time_stable got=%h exp=%h", time_in, frozen); else n_pass++;
      if (time_ow === 1'b1) hi++;
      guard++;
    end
    n_checks++;
    if (hi != OW_HOLD) $display("FAIL commit_ow_cycles got=%0d exp=%0d", hi, OW_HOLD); else n_pass++;
    n_checks++;
    if (field_sel !== 2'd0 || editing !== 1'b0 || time_in !== frozen)
      $display("FAIL commit_back_idle got=%0d/%b/%h exp=0/0/%h", field_sel, editing, time_in, frozen);
    else n_pass++;
  endtask

  task automatic test_reset_in_commit();
    time_cur = rand_legal();
    repeat (4) drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    n_checks++;
    if (time_ow !== 1'b1) $display("FAIL rst_commit_setup got=%b exp=1", time_ow); else n_pass++;
    drive(1, 0, 0, 0);
    n_checks++;
    if ({time_in, time_ow, editing, field_sel} !== 24'h0)
      $display("FAIL rst_in_commit got=%h exp=%h", {time_in, time_ow, editing, field_sel}, 24'h0);
    else n_pass++;
    drive(0, 0, 0, 0);
    n_checks++;
    if (time_ow !== 1'b0) $display("FAIL rst_no_extend got=%b exp=0", time_ow); else n_pass++;
  endtask

`ifdef TIME_SET_TIMEOUT_EN
  task automatic test_timeout();
    logic [19:0] t;
    logic ow_seen;
    t = rand_legal();
    time_cur = t;
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    ow_seen = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) begin
      drive(0, 0, 0, 0);
      ow_seen = ow_seen | time_ow;
    end
    n_checks++;
    if (field_sel !== 2'd2) $display("FAIL timeout_early got=%0d exp=2", field_sel); else n_pass++;
    drive(0, 0, 0, 0);
    ow_seen = ow_seen | time_ow;
    n_checks++;
    if (field_sel !== 2'd0 || editing !== 1'b0 || time_in !== t)
      $display("FAIL timeout_abort got=%0d/%b/%h exp=0/0/%h", field_sel, editing, time_in, t);
    else n_pass++;
    n_checks++;
    if (ow_seen !== 1'b0) $display("FAIL timeout_no_ow got=%b exp=0", ow_seen); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    time_cur = rand_legal();
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    repeat (3 * TIMEOUT_CYCLES) drive(0, 0, 0, 0);
    n_checks++;
    if (field_sel !== 2'd2 || editing !== 1'b1)
      $display("FAIL no_timeout_persist got=%0d/%b exp=2/1", field_sel, editing);
    else n_pass++;
    drive(1, 0, 0, 0);
  endtask
`endif

  task automatic test_random();
    logic [23:0] exp_v;
    for (int i = 0; i < 600; i++) begin
      time_cur = ($urandom_range(0, 1) == 0) ? rand_legal() : 20'($urandom);
      drive(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      exp_v = model_outs();
      n_checks++;
      if ({time_in, time_ow, editing, field_sel} !== exp_v)
        $display("FAIL random_outs cyc=%0d got=%h exp=%h", i, {time_in, time_ow, editing, field_sel}, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; time_cur = '0;
    m_mode = 0; m_left = 0; m_quiet = 0; m_edit = '0;
    test_reset();
    test_enter_edit();
    test_hour_steps();
    test_mode_priority();
    test_minsec();
    test_simultaneous();
    test_commit();
    test_reset_in_commit();
`ifdef TIME_SET_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
